// File: rtl/inst_fetch_bridge.sv
// Fetch bridge between the PC register and an SRAM-like instruction bus.
// Keeps one bus transaction in flight and holds the fetched word until IF/ID takes it.
module inst_fetch_bridge #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter logic [DW-1:0] NOP_INST = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          stallreq_o,
  output logic          inst_req_o,
  output logic [AW-1:0] inst_addr_o,
  input  logic          inst_addr_ok_i,
  input  logic          inst_data_ok_i,
  input  logic [DW-1:0] inst_rdata_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_valid_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;
  localparam logic [1:0] DISCARD   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] req_pc;
  logic [DW-1:0] inst_buf;
  logic          req_fire;

  assign req_fire = inst_req_o & inst_addr_ok_i;

  // Next state. A flush always abandons the current fetch; if the data for an
  // abandoned fetch is still owed by the bus, DISCARD swallows it later.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flush_i)             state_nxt = inst_data_ok_i ? IDLE : DISCARD;
        else if (inst_data_ok_i) state_nxt = DONE;
      end
      DONE: begin
        if (flush_i || !stall_i) state_nxt = IDLE;
      end
      DISCARD: begin
        if (inst_data_ok_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state    <= IDLE;
      req_pc   <= '0;
      inst_buf <= NOP_INST;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_fire) req_pc <= pc_i;
      if (state == WAIT_DATA && inst_data_ok_i && !flush_i) inst_buf <= inst_rdata_i;
      if (state == DONE && (flush_i || !stall_i)) inst_buf <= NOP_INST;
    end
  end

  // Outputs are decoded from state; only IDLE looks at the PC inputs directly
  // so the address reaches the bus in the same cycle the PC presents it.
  always_comb begin
    inst_req_o   = 1'b0;
    inst_addr_o  = req_pc;
    stallreq_o   = 1'b0;
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_pc_o    = '0;
    case (state)
      IDLE: begin
        inst_req_o  = ce_i & ~flush_i & ~rst;
        inst_addr_o = pc_i;
        stallreq_o  = ce_i & ~flush_i;
      end
      WAIT_DATA: begin
        stallreq_o = 1'b1;
      end
      DONE: begin
        inst_valid_o = 1'b1;
        inst_o       = inst_buf;
        inst_pc_o    = req_pc;
      end
      DISCARD: begin
        stallreq_o = 1'b1;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

endmodule
